// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Instruction fetch stage of a 5-stage MIPS pipeline. Holds the
//            program counter, drives the instruction-memory address, picks
//            the next PC (sequential / redirect / exception / ERET) and
//            registers the fetched instruction into the IF/ID register.
// Ports    : clk, reset (sync, active-low)
//            stall, redirect, redirect_pc, d_is_branch  - pipeline control
//            exc_req, eret, epc                         - CP0 control
//            IM_addr (out), IR (in)                     - instruction memory
//            instr_D, pc_D, pc8_D, valid_D, bd_D,
//            exc_D, exc_code_D                          - IF/ID register
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_4FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        d_is_branch,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] IM_addr,
    input  logic [31:0] IR,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        bd_D,
    output logic        exc_D,
    output logic [4:0]  exc_code_D
);

    localparam logic [4:0] C_EXC_ADEL = 5'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_id_q,    pc_id_d;
    logic [31:0] pc8_id_q,   pc8_id_d;
    logic        valid_q,    valid_d;
    logic        bd_q,       bd_d;
    logic        exc_q,      exc_d;
    logic [4:0]  exc_code_q, exc_code_d;

    logic        w_addr_err;
    logic [31:0] w_new_pc;

    // Address error on the PC currently being fetched: misaligned or
    // outside the instruction memory window.
    assign w_addr_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_id_d    = pc_id_q;
        pc8_id_d   = pc8_id_q;
        valid_d    = valid_q;
        bd_d       = bd_q;
        exc_d      = exc_q;
        exc_code_d = exc_code_q;
        w_new_pc   = pc_q;

        if (exc_req || eret) begin
            // Exception beats ERET; both flush IF/ID even under stall.
            w_new_pc   = exc_req ? HANDLER_PC : epc;
            pc_d       = w_new_pc;
            instr_d    = 32'd0;
            pc_id_d    = w_new_pc;
            pc8_id_d   = w_new_pc + 32'd8;
            valid_d    = 1'b0;
            bd_d       = 1'b0;
            exc_d      = 1'b0;
            exc_code_d = 5'd0;
        end else if (!stall) begin
            // The current fetch (possibly a delay slot) is captured in
            // every non-stalled, non-flushed cycle.
            pc_d       = redirect ? redirect_pc : (pc_q + 32'd4);
            instr_d    = w_addr_err ? 32'd0 : IR;
            pc_id_d    = pc_q;
            pc8_id_d   = pc_q + 32'd8;
            valid_d    = 1'b1;
            bd_d       = d_is_branch;
            exc_d      = w_addr_err;
            exc_code_d = w_addr_err ? C_EXC_ADEL : 5'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_id_q    <= RESET_PC;
            pc8_id_q   <= RESET_PC + 32'd8;
            valid_q    <= 1'b0;
            bd_q       <= 1'b0;
            exc_q      <= 1'b0;
            exc_code_q <= 5'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_id_q    <= pc_id_d;
            pc8_id_q   <= pc8_id_d;
            valid_q    <= valid_d;
            bd_q       <= bd_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IM_addr    = pc_q;
    assign instr_D    = instr_q;
    assign pc_D       = pc_id_q;
    assign pc8_D      = pc8_id_q;
    assign valid_D    = valid_q;
    assign bd_D       = bd_q;
    assign exc_D      = exc_q;
    assign exc_code_D = exc_code_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit: directed scenarios then
//            randomized control traffic compared with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] C_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] C_IM_LO      = 32'h0000_3000;
    localparam logic [31:0] C_IM_HI      = 32'h0000_4FFC;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, d_is_branch, exc_req, eret;
    logic [31:0] redirect_pc, epc;
    logic [31:0] IM_addr, IR, instr_D, pc_D, pc8_D;
    logic        valid_D, bd_D, exc_D;
    logic [4:0]  exc_code_D;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (architectural view of PC and IF/ID)
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
    logic        m_valid, m_bd, m_exc;
    logic [4:0]  m_code;

    always #5 clk = ~clk;

    // Instruction memory contents: a PC-derived pattern.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h0001_9E37) ^ 32'hC0DE_0000;
    endfunction

    assign IR = imem(IM_addr);

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_is_branch (d_is_branch),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .IM_addr     (IM_addr),
        .IR          (IR),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .pc8_D       (pc8_D),
        .valid_D     (valid_D),
        .bd_D        (bd_D),
        .exc_D       (exc_D),
        .exc_code_D  (exc_code_D)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ":IM_addr"},    IM_addr,             m_pc);
        check({ctx, ":instr_D"},    instr_D,             m_instr);
        check({ctx, ":pc_D"},       pc_D,                m_pcd);
        check({ctx, ":pc8_D"},      pc8_D,               m_pc8);
        check({ctx, ":valid_D"},    {31'd0, valid_D},    {31'd0, m_valid});
        check({ctx, ":bd_D"},       {31'd0, bd_D},       {31'd0, m_bd});
        check({ctx, ":exc_D"},      {31'd0, exc_D},      {31'd0, m_exc});
        check({ctx, ":exc_code_D"}, {27'd0, exc_code_D}, {27'd0, m_code});
    endtask

    // Empty the IF/ID register and start fetching at 'target'.
    task automatic model_flush(input logic [31:0] target);
        m_pc    = target;
        m_instr = 32'd0;
        m_pcd   = target;
        m_pc8   = target + 32'd8;
        m_valid = 1'b0;
        m_bd    = 1'b0;
        m_exc   = 1'b0;
        m_code  = 5'd0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit bad;
        if (!reset) begin
            model_flush(C_RESET_PC);
        end else if (exc_req) begin
            model_flush(C_HANDLER_PC);
        end else if (eret) begin
            model_flush(epc);
        end else if (!stall) begin
            bad     = (m_pc % 4 != 0) || (m_pc < C_IM_LO) || (m_pc > C_IM_HI);
            m_instr = bad ? 32'd0 : imem(m_pc);
            m_pcd   = m_pc;
            m_pc8   = m_pc + 32'd8;
            m_valid = 1'b1;
            m_bd    = d_is_branch;
            m_exc   = bad;
            m_code  = bad ? 5'd4 : 5'd0;
            m_pc    = redirect ? redirect_pc : m_pc + 32'd4;
        end
    endtask

    // One clock: drive inputs, step the model, clock, then compare.
    task automatic step(input logic rst_n, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic br,
                        input logic ex, input logic er, input logic [31:0] ep,
                        input string ctx);
        reset       = rst_n;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        d_is_branch = br;
        exc_req     = ex;
        eret        = er;
        epc         = ep;
        model_edge();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, ctx);
    endtask

    task automatic jump(input logic [31:0] tgt, input string ctx);
        step(1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 1'b0, 32'd0, ctx);
    endtask

    function automatic logic [31:0] rand_target();
        int sel = $urandom_range(0, 7);
        if (sel < 6) return C_IM_LO + ($urandom_range(0, 2047) << 2);
        return $urandom();
    endfunction

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        d_is_branch = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = 32'd0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "reset");

        // Sequential fetch
        idle("seq0");
        check("seq0_pc_D_const", pc_D, 32'h3000);
        idle("seq1");
        idle("seq2");
        idle("seq3");
        check("seq3_IM_addr_const", IM_addr, 32'h3010);

        // Stall holds PC and IF/ID; a pending redirect is ignored
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1, 32'h3800, 1'b1, 1'b0, 1'b0, 32'd0, "stall");
        check("stall_IM_addr_const", IM_addr, 32'h3010);
        idle("stall_release");
        check("release_IM_addr_const", IM_addr, 32'h3014);

        // Branch with delay slot
        jump(32'h3020, "to3020");
        step(1'b1, 1'b0, 1'b1, 32'h3100, 1'b1, 1'b0, 1'b0, 32'd0, "branch");
        check("branch_IM_addr_const", IM_addr, 32'h3100);
        check("branch_bd_const", {31'd0, bd_D}, 32'd1);

        // Exception and ERET together, then ERET alone
        jump(32'h3040, "to3040");
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h3abc, "exc_eret");
        check("exc_IM_addr_const", IM_addr, 32'h4180);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h3044, "eret");
        // Flush takes priority over stall
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, "exc_stall");

        // Address errors: misaligned, above window, wrap, window edges
        jump(32'h3002, "to3002");
        idle("misaligned");
        check("misaligned_code_const", {27'd0, exc_code_D}, 32'd4);
        jump(32'h5000, "to5000");
        idle("above_hi");
        jump(32'h4FFC, "to4ffc");
        idle("at_hi");
        idle("past_hi");
        jump(32'h2FFC, "to2ffc");
        idle("below_lo");
        jump(32'hFFFF_FFFC, "towrap");
        idle("wrap0");
        idle("wrap1");
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h3001, "eret_misaligned");
        idle("eret_misaligned_fetch");

        // Reset overrides stall and exception
        step(1'b0, 1'b1, 1'b1, 32'h3100, 1'b1, 1'b1, 1'b1, 32'h3200, "reset_mid");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), rand_target(),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), rand_target(),
                 "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch stage of the 5-stage MIPS pipeline. Directly upstream of the instruction memory.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from these sources: sequential, branch/jump redirect, exception entry, ERET return.
- Registers the returned instruction into the IF/ID pipeline register, together with PC, PC+8, the delay-slot flag and fetch-exception status.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_4FFC, highest legal fetch address (2048 words).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- stall, input, 1, hazard stall: hold PC and IF/ID.
- redirect, input, 1, branch taken or jump resolved in the D stage.
- redirect_pc, input, 32, target of redirect.
- d_is_branch, input, 1, instruction in D is a branch/jump, so the current fetch is a delay slot.
- exc_req, input, 1, exception/interrupt committed by CP0.
- eret, input, 1, ERET committed.
- epc, input, 32, return address for ERET.
- IM_addr, output, 32, fetch address to instruction memory (= PC, combinational).
- IR, input, 32, instruction returned combinationally by instruction memory.
- instr_D, output, 32, IF/ID instruction.
- pc_D, output, 32, IF/ID PC.
- pc8_D, output, 32, IF/ID PC+8 (link value).
- valid_D, output, 1, IF/ID holds a real fetch, not a bubble.
- bd_D, output, 1, IF/ID instruction is in a branch delay slot.
- exc_D, output, 1, fetch raised an address error.
- exc_code_D, output, 5, exception code (4 = AdEL when exc_D=1, else 0).

Behaviour:

Reset (reset==0 at posedge):
- PC=RESET_PC.
- instr_D=0, pc_D=RESET_PC, pc8_D=RESET_PC+8.
- valid_D=0, bd_D=0, exc_D=0, exc_code_D=0.
- Reset overrides every other input in the same cycle.

IM_addr:
- IM_addr=PC at all times. Fetch latency is 0 cycles (memory is combinational).
- The IR sampled at a posedge belongs to the PC held before that edge.

Fetch address error:
- Raised when PC[1:0]!=0, or PC<IM_LO, or PC>IM_HI.
- On error the IF/ID load captures instr_D=0 (NOP), exc_D=1, exc_code_D=5'd4, valid_D=1.
- IR is ignored in that case.

Next-PC priority, evaluated each posedge with reset==1 (first match wins):
1. exc_req: PC=HANDLER_PC. Flush IF/ID.
2. eret: PC=epc. Flush IF/ID.
3. stall: PC and all IF/ID outputs hold. Any redirect is ignored; the D stage keeps presenting it until the stall drops.
4. redirect: PC=redirect_pc. IF/ID loads the current fetch (the delay slot) normally.
5. Otherwise: PC=PC+4. IF/ID loads the current fetch.

IF/ID rules:
- Flush: instr_D=0, valid_D=0, bd_D=0, exc_D=0, exc_code_D=0. pc_D=the new PC; pc8_D=new PC+8.
- Normal load: instr_D=IR (or 0 on address error), pc_D=PC, pc8_D=PC+8, valid_D=1, bd_D=d_is_branch.
- Simultaneous exc_req and eret: exception wins; eret is dropped.
- exc_req or eret together with stall: the flush still occurs, and the PC still loads.

Arithmetic:
- PC+4 and PC+8 are 32-bit, mod 2^32. No saturation.
- A PC that wraps past IM_HI raises AdEL on the next fetch; the PC does not stick.

Misaligned targets:
- A misaligned redirect_pc or epc is loaded as given. The error is flagged on the following fetch.

Test Plan:
1. Reset deasserted, no stall, IR=PC-derived pattern -> IM_addr steps 0x3000, 0x3004, 0x3008; pc_D lags one cycle; pc8_D=pc_D+8; valid_D=1 from the 2nd edge.
2. stall=1 for 3 cycles at PC=0x3010 -> IM_addr stays 0x3010; instr_D and pc_D are frozen; on release, PC=0x3014.
3. d_is_branch=1 and redirect=1, redirect_pc=0x3100, at PC=0x3020 -> next IM_addr=0x3100; IF/ID holds 0x3020 with bd_D=1.
4. exc_req=1 and eret=1 in the same cycle at PC=0x3040 -> PC=0x4180; valid_D=0; instr_D=0. Next cycle eret=1, epc=0x3044 -> PC=0x3044, IF/ID flushed.
5. redirect_pc=0x3002 -> next edge: exc_D=1, exc_code_D=4, instr_D=0, pc_D=0x3002. Separately, jump to 0x5000 -> same AdEL flag.
6. reset=0 asserted mid-stream, with stall=1 and exc_req=1 also asserted -> after one edge, PC=0x3000 and all IF/ID outputs are at reset values.
